// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB command master and the UART register map it drives.
// Command widths here set the default bus widths of apb_cmd_master.
package apb_uart_pkg;

    localparam int APB_ADDR_W = 10;
    localparam int APB_DATA_W = 32;

    localparam logic [APB_ADDR_W-1:0] UART_DATA   = 10'h000;
    localparam logic [APB_ADDR_W-1:0] UART_STATUS = 10'h001;
    localparam logic [APB_ADDR_W-1:0] UART_CTRL   = 10'h002;
    localparam logic [APB_ADDR_W-1:0] UART_INT    = 10'h003;
    localparam logic [APB_ADDR_W-1:0] UART_BAUD   = 10'h004;
    localparam logic [APB_ADDR_W-1:0] UART_PARITY = 10'h005;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command FIFO with count-based full/empty; a push into a full FIFO is dropped even
// when a pop happens on the same edge.
module apb_cmd_fifo
    import apb_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_push,
    input  apb_cmd_t i_data,
    input  logic     i_pop,
    output apb_cmd_t o_data,
    output logic     o_full,
    output logic     o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    apb_cmd_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/apb_cmd_master.sv
// Command-driven APB3 master: queued read/write commands become SETUP/ACCESS transfers,
// each answered by one held response carrying read data, slave error or timeout.
module apb_cmd_master
    import apb_uart_pkg::*;
#(
    parameter int ADDR_W     = APB_ADDR_W,
    parameter int DATA_W     = APB_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    localparam int                WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_t        r_state;
    logic [WAIT_W-1:0] r_wait;
    apb_cmd_t          w_cmd;
    apb_cmd_t          w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [DATA_W-1:0] w_head_wdata;

    assign w_cmd.write = cmd_write;
    assign w_cmd.addr  = cmd_addr;
    assign w_cmd.wdata = cmd_wdata;
    assign cmd_ready   = !w_full;

    // A new transfer starts only when the response slot is free or being freed this edge.
    assign w_pop = !w_empty && (!rsp_valid || rsp_ready) &&
                   ((r_state == IDLE) || ((r_state == ACCESS) && PREADY));
    assign w_head_wdata = w_head.write ? w_head.wdata : '0;

    apb_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk  (PCLK),
        .i_rst  (PRESET),
        .i_push (cmd_valid),
        .i_data (w_cmd),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= IDLE;
            r_wait      <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state <= SETUP;
                        PSEL    <= 1'b1;
                        PWRITE  <= w_head.write;
                        PADDR   <= w_head.addr;
                        PWDATA  <= w_head_wdata;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        r_wait      <= '0;
                        PENABLE     <= 1'b0;
                        if (w_pop) begin
                            r_state <= SETUP;
                            PWRITE  <= w_head.write;
                            PADDR   <= w_head.addr;
                            PWDATA  <= w_head_wdata;
                        end else begin
                            r_state <= IDLE;
                            PSEL    <= 1'b0;
                        end
                    end else if ((TIMEOUT != 0) && (r_wait == WAIT_LAST)) begin
                        r_state     <= IDLE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        r_wait      <= '0;
                    end else if (r_wait != '1) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: the bench plays the APB slave and the command/response
// consumer, checking bus and response values against hand-derived expectations.
module tb_apb_cmd_master;
    import apb_uart_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [9:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int total = 0;
    int bad   = 0;
    int n_en;
    int n_rsp;
    int accepted;
    logic [7:0] exp_sel;
    logic [7:0] exp_en;
    logic [7:0] exp_rv;

    apb_cmd_master #(
        .ADDR_W(10), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic wr, input logic [9:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
        tick();
        tick();
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_paddr", PADDR, 0);
        chk("rst_rsp_err", rsp_err, 0);
        PRESET = 1'b0;

        // single zero-wait write
        offer(1'b1, UART_CTRL, 32'h3F);
        tick();
        cmd_valid = 1'b0;
        chk("t1_idle_psel", PSEL, 0);
        tick();
        chk("t1_setup_psel", PSEL, 1);
        chk("t1_setup_penable", PENABLE, 0);
        chk("t1_setup_paddr", PADDR, 32'h002);
        chk("t1_setup_pwdata", PWDATA, 32'h3F);
        chk("t1_setup_pwrite", PWRITE, 1);
        tick();
        chk("t1_access_psel", PSEL, 1);
        chk("t1_access_penable", PENABLE, 1);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_rsp_rdata", rsp_rdata, 0);
        chk("t1_done_psel", PSEL, 0);
        rsp_ready = 1'b1;
        tick();
        chk("t1_rsp_cleared", rsp_valid, 0);
        rsp_ready = 1'b0;

        // read with two wait states
        PREADY = 1'b0;
        offer(1'b0, UART_STATUS, 32'hFFFF_FFFF);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t2_setup_paddr", PADDR, 32'h001);
        chk("t2_setup_pwrite", PWRITE, 0);
        chk("t2_setup_pwdata", PWDATA, 0);
        tick();
        tick();
        tick();
        chk("t2_wait_penable", PENABLE, 1);
        chk("t2_wait_rsp_valid", rsp_valid, 0);
        PREADY = 1'b1;
        PRDATA = 32'h0000_0005;
        tick();
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_rdata", rsp_rdata, 32'h5);
        chk("t2_rsp_err", rsp_err, 0);
        chk("t2_done_psel", PSEL, 0);

        // pending response blocks the next launch
        PRDATA = '0;
        offer(1'b1, UART_INT, 32'h7);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("t5_blocked_psel", PSEL, 0);
        chk("t5_hold_valid", rsp_valid, 1);
        chk("t5_hold_rdata", rsp_rdata, 32'h5);
        rsp_ready = 1'b1;
        tick();
        chk("t5_launch_psel", PSEL, 1);
        chk("t5_launch_penable", PENABLE, 0);
        chk("t5_launch_paddr", PADDR, 32'h003);
        chk("t5_consumed", rsp_valid, 0);
        tick();
        tick();
        chk("t5_rsp_valid", rsp_valid, 1);
        tick();
        chk("t5_rsp_cleared", rsp_valid, 0);

        // slave error on a read keeps PRDATA
        PSLVERR = 1'b1;
        PRDATA  = 32'hA5;
        offer(1'b0, UART_PARITY, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("err_rsp_valid", rsp_valid, 1);
        chk("err_rsp_err", rsp_err, 1);
        chk("err_rsp_timeout", rsp_timeout, 0);
        chk("err_rsp_rdata", rsp_rdata, 32'hA5);
        PSLVERR = 1'b0;
        PRDATA  = '0;
        tick();
        chk("err_rsp_cleared", rsp_valid, 0);

        // three back-to-back zero-wait writes
        exp_sel = 8'b0111_1110;
        exp_en  = 8'b0101_0100;
        exp_rv  = 8'b1010_1000;
        n_rsp   = 0;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: offer(1'b1, UART_DATA, 32'h12);
                1: offer(1'b1, UART_CTRL, 32'h3F);
                2: offer(1'b1, UART_BAUD, 32'h10);
                default: cmd_valid = 1'b0;
            endcase
            tick();
            chk($sformatf("b2b_psel_%0d", i), PSEL, 32'(exp_sel[i]));
            chk($sformatf("b2b_penable_%0d", i), PENABLE, 32'(exp_en[i]));
            chk($sformatf("b2b_rsp_valid_%0d", i), rsp_valid, 32'(exp_rv[i]));
            if (rsp_valid) n_rsp++;
            if (i == 3) chk("b2b_paddr_2", PADDR, 32'h002);
            if (i == 5) chk("b2b_pwdata_3", PWDATA, 32'h10);
        end
        chk("b2b_rsp_count", n_rsp, 3);
        tick();
        chk("b2b_rsp_cleared", rsp_valid, 0);

        // stalled slave: FIFO fills, then timeout abort
        PREADY   = 1'b0;
        accepted = 0;
        n_en     = 0;
        for (int i = 0; i < 6; i++) begin
            offer(1'b1, 10'(i), 32'(i + 1));
            if (cmd_ready) accepted++;
            tick();
            if (PENABLE) n_en++;
        end
        cmd_valid = 1'b0;
        chk("to_accepted", accepted, 5);
        chk("to_cmd_ready_full", cmd_ready, 0);
        for (int k = 0; k < 40 && !rsp_valid; k++) begin
            tick();
            if (PENABLE) n_en++;
        end
        chk("to_access_cycles", n_en, 16);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_psel", PSEL, 0);

        // reset in ACCESS with three commands still queued
        tick();
        tick();
        tick();
        chk("rstx_in_access", PENABLE, 1);
        chk("rstx_paddr", PADDR, 32'h001);
        chk("rstx_cmd_ready", cmd_ready, 1);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        PREADY = 1'b1;
        chk("rstx_psel", PSEL, 0);
        chk("rstx_penable", PENABLE, 0);
        chk("rstx_rsp_valid", rsp_valid, 0);
        chk("rstx_cmd_ready_after", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rstx_quiet_%0d", i), PSEL, 0);
        end

        // bus works again after the flush
        PRDATA = 32'h10;
        offer(1'b0, UART_BAUD, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("post_setup_psel", PSEL, 1);
        chk("post_setup_paddr", PADDR, 32'h004);
        tick();
        tick();
        chk("post_rsp_valid", rsp_valid, 1);
        chk("post_rsp_rdata", rsp_rdata, 32'h10);
        chk("post_rsp_timeout", rsp_timeout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
